// File: rtl/nebula_pkg.sv
// Shared constants for the Nebula NoC router arbiters.
package nebula_pkg;

   localparam int NEBULA_DEFAULT_REQS = 4;

endpackage : nebula_pkg

// File: rtl/nebula_fixed_prio_enc.sv
// LSB-first fixed-priority encoder: lowest set bit wins, reported as one-hot, index and valid.
module nebula_fixed_prio_enc #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   output logic [N-1:0] onehot,
   output logic [W-1:0] idx,
   output logic         valid
);

   always_comb begin
      onehot = '0;
      idx    = '0;
      valid  = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (req[i] && !valid) begin
            onehot[i] = 1'b1;
            idx       = W'(i);
            valid     = 1'b1;
         end
      end
   end

endmodule : nebula_fixed_prio_enc

// File: rtl/nebula_rr_arbiter.sv
// Round-robin arbiter: combinational grant from req and a registered priority pointer
// that moves one past the last winner.
module nebula_rr_arbiter
   import nebula_pkg::*;
#(
   parameter int NUM_REQS  = NEBULA_DEFAULT_REQS,
   parameter int REQ_WIDTH = $clog2(NUM_REQS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQS-1:0]  req,
   output logic [NUM_REQS-1:0]  grant,
   output logic                 grant_valid,
   output logic [REQ_WIDTH-1:0] grant_id
);

   // No handshake: a valid grant is consumed in the cycle it is shown; callers gate req.

   logic [REQ_WIDTH-1:0] prio_ptr_q, prio_ptr_d;
   logic [NUM_REQS-1:0]  mask;
   logic [NUM_REQS-1:0]  masked_req;
   logic [NUM_REQS-1:0]  masked_onehot, unmasked_onehot;
   logic [REQ_WIDTH-1:0] masked_idx, unmasked_idx;
   logic                 masked_valid, unmasked_valid;

   always_comb begin
      mask = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         mask[i] = (REQ_WIDTH'(i) >= prio_ptr_q);
      end
   end

   assign masked_req = req & mask;

   nebula_fixed_prio_enc #(.N(NUM_REQS), .W(REQ_WIDTH)) u_masked_enc (
      .req    (masked_req),
      .onehot (masked_onehot),
      .idx    (masked_idx),
      .valid  (masked_valid)
   );

   nebula_fixed_prio_enc #(.N(NUM_REQS), .W(REQ_WIDTH)) u_unmasked_enc (
      .req    (req),
      .onehot (unmasked_onehot),
      .idx    (unmasked_idx),
      .valid  (unmasked_valid)
   );

   // Masked path covers ptr..N-1; when empty, the unmasked pick supplies the wrap to 0..ptr-1.
   always_comb begin
      grant       = masked_valid ? masked_onehot : unmasked_onehot;
      grant_id    = masked_valid ? masked_idx    : unmasked_idx;
      grant_valid = masked_valid | unmasked_valid;
   end

   always_comb begin
      prio_ptr_d = prio_ptr_q;
      if (grant_valid) begin
         if (grant_id == REQ_WIDTH'(NUM_REQS - 1)) begin
            prio_ptr_d = '0;
         end else begin
            prio_ptr_d = grant_id + REQ_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prio_ptr_q <= '0;
      end else begin
         prio_ptr_q <= prio_ptr_d;
      end
   end

endmodule : nebula_rr_arbiter

// File: tb/tb_nebula_rr_arbiter.sv
// Directed vector table plus multi-cycle sequences for the 5-port round-robin arbiter.
module tb_nebula_rr_arbiter;

   localparam int N = 5;
   localparam int W = 3;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] req;
   logic [N-1:0] grant;
   logic         grant_valid;
   logic [W-1:0] grant_id;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic         rst;
      logic [N-1:0] req;
      logic [N-1:0] exp_grant;
      logic         exp_valid;
      logic [W-1:0] exp_id;
   } vec_t;

   vec_t vecs[$];

   nebula_rr_arbiter #(.NUM_REQS(N), .REQ_WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void add(input logic r, input logic [N-1:0] rq, input logic v, input int id);
      vec_t e;
      e.rst       = r;
      e.req       = rq;
      e.exp_valid = v;
      e.exp_id    = v ? W'(id) : '0;
      e.exp_grant = v ? (N'(1) << id) : '0;
      vecs.push_back(e);
   endfunction

   task automatic step_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outputs(input string name, input logic [N-1:0] eg, input logic ev,
                                input logic [W-1:0] eid);
      check({name, ".grant"}, int'(grant), int'(eg));
      check({name, ".valid"}, int'(grant_valid), int'(ev));
      check({name, ".id"}, int'(grant_id), int'(eid));
   endtask

   initial begin
      int counts[N];
      logic [W-1:0] ptr_m;
      logic [N-1:0] exp_g;
      int exp_i;

      rst_n = 1'b0;
      req   = '0;

      // reset with idle requests
      add(1'b1, 5'b00000, 1'b0, 0);
      add(1'b1, 5'b00000, 1'b0, 0);
      // idle after reset, pointer 0
      add(1'b0, 5'b00000, 1'b0, 0);
      // single requests, each followed by an idle cycle
      for (int i = 0; i < N; i++) begin
         add(1'b0, N'(1) << i, 1'b1, i);
         add(1'b0, 5'b00000, 1'b0, 0);
      end
      // pointer now 0: single request ahead of pointer, then one behind it
      add(1'b0, 5'b00100, 1'b1, 2);   // ptr -> 3
      add(1'b0, 5'b00010, 1'b1, 1);   // wrap pick, ptr -> 2
      // reset back to pointer 0
      add(1'b1, 5'b00000, 1'b0, 0);
      // full rotation, 15 cycles
      for (int i = 0; i < 15; i++) add(1'b0, 5'b11111, 1'b1, i % N);
      // partial set from pointer 0
      add(1'b0, 5'b10100, 1'b1, 2);
      add(1'b0, 5'b10100, 1'b1, 4);
      add(1'b0, 5'b10100, 1'b1, 2);
      add(1'b0, 5'b10100, 1'b1, 4);
      add(1'b0, 5'b10100, 1'b1, 2);   // ptr -> 3
      add(1'b0, 5'b00011, 1'b1, 0);
      add(1'b0, 5'b00011, 1'b1, 1);   // ptr -> 2

      foreach (counts[k]) counts[k] = 0;
      for (int v = 0; v < vecs.size(); v++) begin
         rst_n = ~vecs[v].rst;
         req   = vecs[v].req;
         #1;
         check_outputs($sformatf("vec%0d", v), vecs[v].exp_grant, vecs[v].exp_valid,
                       vecs[v].exp_id);
         if (vecs[v].req == 5'b11111 && grant_valid) counts[grant_id]++;
         step_edge();
      end
      for (int k = 0; k < N; k++) check($sformatf("rotation_count%0d", k), counts[k], 3);

      // mid-run reset: pointer 2, all requesting
      rst_n = 1'b1;
      req   = 5'b11111;
      #1 check_outputs("midrst_a", 5'b00100, 1'b1, 3'd2);
      step_edge();
      check_outputs("midrst_b", 5'b01000, 1'b1, 3'd3);
      step_edge();
      rst_n = 1'b0;
      #1 check_outputs("midrst_during", 5'b10000, 1'b1, 3'd4);
      step_edge();
      rst_n = 1'b1;
      #1 check_outputs("midrst_after", 5'b00001, 1'b1, 3'd0);
      step_edge();
      check_outputs("midrst_next", 5'b00010, 1'b1, 3'd1);
      step_edge();

      // random traffic against a circular-scan reference, pointer now 2
      ptr_m = 3'd2;
      for (int c = 0; c < 100; c++) begin
         req = ($urandom_range(0, 7) == 0) ? 5'b00000 : N'($urandom_range(0, 31));
         #1;
         exp_g = '0;
         exp_i = 0;
         for (int k = 0; k < N; k++) begin
            int p;
            p = (int'(ptr_m) + k) % N;
            if (req[p] && exp_g == '0) begin
               exp_g = N'(1) << p;
               exp_i = p;
            end
         end
         check("rand_onehot0", int'($onehot0(grant)), 1);
         check("rand_subset", int'((grant & ~req) == '0), 1);
         check("rand_valid_or", int'(grant_valid), int'(|req));
         if (grant_valid) check("rand_id_bit", int'(grant[grant_id]), 1);
         check_outputs($sformatf("rand%0d", c), exp_g, |req, W'(exp_i));
         if (exp_g != '0) ptr_m = (exp_i == N - 1) ? '0 : W'(exp_i + 1);
         step_edge();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_nebula_rr_arbiter

// File: doc/nebula_rr_arbiter.md
# nebula_rr_arbiter

Parameterised round-robin arbiter for the Nebula NoC router, used by switch allocation and output-port arbitration. It selects one of `NUM_REQS` requesters per cycle and returns a one-hot grant plus its encoded index. Grant is combinational from the current request vector and a registered priority pointer. The pointer rotates past the last winner, so every continuously asserting requester is served within `NUM_REQS` cycles.

## Interface
Parameters:
- `NUM_REQS`, default 4: number of requesters; must be ≥ 2; non-power-of-two values are supported (e.g. 5).
- `REQ_WIDTH`, default `$clog2(NUM_REQS)`: width of `grant_id`.

Ports:
- `clk`, input, 1: clock, rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `req`, input, `NUM_REQS`: request vector, one bit per requester.
- `grant`, output, `NUM_REQS`: one-hot grant vector; all zero when no request.
- `grant_valid`, output, 1: high iff `grant` is non-zero.
- `grant_id`, output, `REQ_WIDTH`: binary index of the granted requester; 0 when `grant_valid` = 0.

## Operation
- State: a priority pointer `prio_ptr` (`REQ_WIDTH` bits, range 0..`NUM_REQS`-1) naming the highest-priority requester.
- Grant selection:
  - Scan circularly from `prio_ptr` upward: `prio_ptr`, `prio_ptr`+1, …, `NUM_REQS`-1, 0, …, `prio_ptr`-1.
  - The first asserted `req` bit wins.
- Implementation: double-width masked priority encode.
  - Masked requests are `req` with bits at or above `prio_ptr`.
  - If the masked vector is non-zero, fixed-priority-pick it (lowest index).
  - Otherwise fixed-priority-pick the unmasked `req`.
- Output invariants, always:
  - `grant` = 0 or one-hot.
  - `grant` is a subset of `req`.
  - `grant_valid` = |`grant`.
  - `grant[grant_id]` = 1 whenever `grant_valid`.
- Pointer update at each rising edge, `rst_n` high:
  - If `grant_valid`: `prio_ptr` ← `grant_id`+1, wrapping to 0 when `grant_id` = `NUM_REQS`-1. Wrap is explicit modulo `NUM_REQS`, not power of two.
  - Otherwise `prio_ptr` holds.
- No request (`req` = 0): `grant` = 0, `grant_valid` = 0, `grant_id` = 0, pointer unchanged.
- Single requester: always granted in the same cycle, regardless of pointer position.
- All requesters active: grants rotate strictly 0,1,2,…,`NUM_REQS`-1,0,…
  - Over any `NUM_REQS` consecutive cycles each requester gets exactly one grant.
  - Max–min grant count over any window ≤ 1.
- Starvation bound: a requester holding `req` high is granted within `NUM_REQS` cycles.
- No acknowledge or hold: a grant is consumed every cycle it is valid. The caller must gate `req` if it cannot accept.

## Timing
- Grant path is combinational, zero latency: `req` change → `grant`, `grant_valid`, `grant_id` in the same cycle. No output registers.
- Pointer is the only flop.
- Reset:
  - `rst_n` low at a rising edge sets `prio_ptr` ← 0, so requester 0 has top priority after reset.
  - The pointer does not advance while `rst_n` is low.
  - Outputs remain a combinational function of `req` and `prio_ptr` during reset. With `req` = 0 all outputs are 0.
- Mid-operation reset: pointer returns to 0 on the first reset edge. The first grant after release starts from requester 0.
- `req` may change every cycle. The pointer reflects the grant present just before the edge.

## Structure
- `nebula_pkg` holds any shared arbiter constants/typedefs (e.g. default port count). The arbiter imports it; no local typedef duplication.
- One sub-module is natural: `nebula_fixed_prio_enc`, an LSB-first priority encoder producing one-hot, index and valid. It is instantiated twice (masked and unmasked paths).
- Top level contains the mask generation, path mux, pointer register and wrap logic.

## Test plan
All scenarios use `NUM_REQS` = 5.
- Idle: after reset, `req` = 0 → `grant` = 0, `grant_valid` = 0, `grant_id` = 0.
- Single request: `req` = 1<<i for i = 0..4, each followed by an idle cycle → `grant` = 1<<i, `grant_valid` = 1, `grant_id` = i.
- Rotation: `req` = 5'b11111 held for 15 cycles → `grant_id` sequence increments mod 5 each cycle; each requester gets exactly 3 grants.
- Partial set: pointer at 0, `req` = 5'b10100 held → `grant_id` alternates 2, 4, 2, 4.
  - Then change `req` to 5'b00011 while the pointer is at 3 → `grant_id` = 0 (wrap), then 1.
- Reset mid-run: `req` all ones, pulse `rst_n` low for one edge after grant_id = 3 → next grant with all requests is 0.
- Random: 100 cycles of random `req` → every cycle the one-hot, subset-of-`req`, `grant[grant_id]` and `grant_valid` = |`req` invariants hold.
